// File: rtl/wbuffer_pkg.sv
// wbuffer_pkg: shared types and sizing for the post-retire store write buffer.
package wbuffer_pkg;
   localparam int WBUF_DEPTH = 8;
   localparam int WBUF_ENQ_WIDTH = 2;
   typedef logic [2:0] msize_t;
   typedef logic [$clog2(WBUF_DEPTH):0] wbuf_ptr_t;
   typedef enum logic [1:0] {IDLE, REQ, WAIT} wbuf_state_t;
   typedef struct packed {
      logic [63:0] addr;
      logic [63:0] data;
      logic [7:0]  strobe;
      msize_t      size;
   } wbuf_entry_t;
endpackage

// File: rtl/wbuf_fwd_merge.sv
// wbuf_fwd_merge: per-byte youngest-match select over entries ordered oldest (index 0) to youngest.
module wbuf_fwd_merge #(
   parameter int DEPTH = 8
) (
   input  logic [60:0]      tag [DEPTH],
   input  logic [63:0]      data [DEPTH],
   input  logic [7:0]       strb [DEPTH],
   input  logic [DEPTH-1:0] vld,
   input  logic [60:0]      lq_tag,
   output logic [7:0]       lq_strobe,
   output logic [63:0]      lq_data
);
   always_comb begin
      lq_strobe = '0;
      lq_data = '0;
      for (int k = 0; k < DEPTH; k++)
         for (int b = 0; b < 8; b++)
            if (vld[k] && tag[k] == lq_tag && strb[k][b]) begin
               lq_strobe[b] = 1'b1;
               lq_data[8*b +: 8] = data[k][8*b +: 8];
            end
   end
endmodule

// File: rtl/store_wbuffer.sv
// store_wbuffer: in-order post-retire store buffer draining one store at a time to the D-bus,
// with byte-granular forwarding to younger loads.
module store_wbuffer
   import wbuffer_pkg::*;
#(
   parameter int DEPTH = WBUF_DEPTH,
   parameter int ENQ_WIDTH = WBUF_ENQ_WIDTH
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [ENQ_WIDTH-1:0]             creq_valid,
   input  logic [ENQ_WIDTH-1:0][63:0]       creq_addr,
   input  logic [ENQ_WIDTH-1:0][63:0]       creq_data,
   input  logic [ENQ_WIDTH-1:0][7:0]        creq_strobe,
   input  logic [ENQ_WIDTH-1:0][2:0]        creq_size,
   output logic                             creq_ready,
   output logic                             dreq_valid,
   output logic [63:0]                      dreq_addr,
   output logic [63:0]                      dreq_data,
   output logic [7:0]                       dreq_strobe,
   output logic [2:0]                       dreq_size,
   input  logic                             dresp_addr_ok,
   input  logic                             dresp_data_ok,
   input  logic [63:0]                      lq_addr,
   output logic [7:0]                       lq_strobe,
   output logic [63:0]                      lq_data,
   output logic                             empty,
   output logic [$clog2(DEPTH):0]           count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] RDY_MAX = (AW+1)'(DEPTH-2);
   wbuf_entry_t mem [DEPTH];
   logic [DEPTH-1:0] vld, f_vld;
   logic [AW:0] head, tail, push;
   logic [AW-1:0] hd;
   logic [AW-1:0] wr_idx [ENQ_WIDTH];
   logic [60:0] f_tag [DEPTH];
   logic [63:0] f_data [DEPTH];
   logic [7:0] f_strb [DEPTH];
   wbuf_state_t state, state_n;
   logic pop, more;
   assign hd = head[AW-1:0];
   assign count = tail - head;
   assign creq_ready = count <= RDY_MAX;
   assign more = count > (AW+1)'(1);
   assign empty = count == '0 && state == IDLE;
   assign dreq_valid = state == REQ;
   assign dreq_addr = mem[hd].addr;
   assign dreq_data = mem[hd].data;
   assign dreq_strobe = mem[hd].strobe;
   assign dreq_size = mem[hd].size;
   assign pop = (state == REQ && dresp_addr_ok && dresp_data_ok) || (state == WAIT && dresp_data_ok);
   // valid slots are packed together at tail, slot0 first
   always_comb begin
      push = '0;
      for (int i = 0; i < ENQ_WIDTH; i++) begin
         wr_idx[i] = tail[AW-1:0] + push[AW-1:0];
         push = push + (AW+1)'(creq_valid[i]);
      end
   end
   always_comb begin
      state_n = state;
      state_n = state == IDLE ? (count != '0 ? REQ : IDLE)
              : state == REQ  ? (pop ? (more ? REQ : IDLE) : dresp_addr_ok ? WAIT : REQ)
              :                 (pop ? (more ? REQ : IDLE) : WAIT);
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head <= '0;
         tail <= '0;
         vld <= '0;
         state <= IDLE;
      end else begin
         state <= state_n;
         if (pop) begin
            vld[hd] <= 1'b0;
            head <= head + (AW+1)'(1);
         end
         if (creq_ready) begin
            tail <= tail + push;
            for (int i = 0; i < ENQ_WIDTH; i++)
               if (creq_valid[i]) vld[wr_idx[i]] <= 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (creq_ready)
         for (int i = 0; i < ENQ_WIDTH; i++)
            if (creq_valid[i]) mem[wr_idx[i]] <= '{creq_addr[i], creq_data[i], creq_strobe[i], creq_size[i]};
   end
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         f_tag[k] = mem[hd + AW'(k)].addr[63:3];
         f_data[k] = mem[hd + AW'(k)].data;
         f_strb[k] = mem[hd + AW'(k)].strobe;
         f_vld[k] = vld[hd + AW'(k)];
      end
   end
   wbuf_fwd_merge #(.DEPTH(DEPTH)) u_fwd (
      .tag(f_tag),
      .data(f_data),
      .strb(f_strb),
      .vld(f_vld),
      .lq_tag(lq_addr[63:3]),
      .lq_strobe(lq_strobe),
      .lq_data(lq_data)
   );
endmodule

// File: tb/tb_store_wbuffer.sv
// tb_store_wbuffer: directed checks of enqueue, in-order drain, forwarding and reset of store_wbuffer.
module tb_store_wbuffer;
   logic clk = 0, reset = 0;
   logic [1:0] creq_valid = '0;
   logic [1:0][63:0] creq_addr = '0, creq_data = '0;
   logic [1:0][7:0] creq_strobe = '0;
   logic [1:0][2:0] creq_size = '0;
   logic creq_ready, dreq_valid, empty;
   logic [63:0] dreq_addr, dreq_data, lq_data;
   logic [7:0] dreq_strobe, lq_strobe;
   logic [2:0] dreq_size;
   logic dresp_addr_ok = 0, dresp_data_ok = 0;
   logic [63:0] lq_addr = '0;
   logic [3:0] count;
   int passed = 0, total = 0;
   typedef struct {
      logic [63:0] lq;
      logic [7:0]  strb;
      logic [63:0] data;
   } fvec_t;
   fvec_t vecs [6];

   store_wbuffer dut (
      .clk(clk), .reset(reset),
      .creq_valid(creq_valid), .creq_addr(creq_addr), .creq_data(creq_data),
      .creq_strobe(creq_strobe), .creq_size(creq_size), .creq_ready(creq_ready),
      .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_data(dreq_data),
      .dreq_strobe(dreq_strobe), .dreq_size(dreq_size),
      .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
      .lq_addr(lq_addr), .lq_strobe(lq_strobe), .lq_data(lq_data),
      .empty(empty), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 0;
      creq_valid = '0;
      dresp_addr_ok = 0;
      dresp_data_ok = 0;
      tick();
      tick();
      reset = 1;
      tick();
   endtask

   task automatic enq(input logic [1:0] v, input logic [63:0] a0, input logic [63:0] d0, input logic [7:0] s0,
                      input logic [63:0] a1, input logic [63:0] d1, input logic [7:0] s1);
      creq_valid = v;
      creq_addr[0] = a0; creq_data[0] = d0; creq_strobe[0] = s0; creq_size[0] = 3'd3;
      creq_addr[1] = a1; creq_data[1] = d1; creq_strobe[1] = s1; creq_size[1] = 3'd3;
      tick();
      creq_valid = '0;
   endtask

   task automatic wait_req(input string name);
      for (int i = 0; i < 20 && !dreq_valid; i++) tick();
      chk(name, 64'(dreq_valid), 64'd1);
   endtask

   task automatic drain_one(input string name, input logic [63:0] exp_addr);
      wait_req({name, "_req"});
      chk(name, dreq_addr, exp_addr);
      dresp_addr_ok = 1;
      dresp_data_ok = 1;
      tick();
      dresp_addr_ok = 0;
      dresp_data_ok = 0;
   endtask

   initial begin
      #1;
      chk("rst_ready", 64'(creq_ready), 64'd1);
      chk("rst_dvalid", 64'(dreq_valid), 64'd0);
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_lqstrb", 64'(lq_strobe), 64'd0);
      do_reset();

      enq(2'b01, 64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, 64'h0, 8'h0);
      chk("t1_count", 64'(count), 64'd1);
      wait_req("t1_req");
      chk("t1_addr", dreq_addr, 64'h8000_0008);
      chk("t1_data", dreq_data, 64'h1122_3344_5566_7788);
      chk("t1_strb", 64'(dreq_strobe), 64'hFF);
      dresp_addr_ok = 1; dresp_data_ok = 1;
      tick();
      dresp_addr_ok = 0; dresp_data_ok = 0;
      chk("t1_empty", 64'(empty), 64'd1);
      chk("t1_count0", 64'(count), 64'd0);
      tick();
      chk("t1_once", 64'(dreq_valid), 64'd0);

      do_reset();
      creq_size[1] = 3'd2;
      creq_valid = 2'b10;
      creq_addr[1] = 64'h2000_0010; creq_data[1] = 64'hCAFE_F00D_DEAD_BEEF; creq_strobe[1] = 8'h3C;
      tick();
      creq_valid = '0;
      chk("t2_count", 64'(count), 64'd1);
      wait_req("t2_req");
      chk("t2_addr", dreq_addr, 64'h2000_0010);
      chk("t2_data", dreq_data, 64'hCAFE_F00D_DEAD_BEEF);
      chk("t2_strb", 64'(dreq_strobe), 64'h3C);
      chk("t2_size", 64'(dreq_size), 64'd2);
      drain_one("t2_drain", 64'h2000_0010);
      chk("t2_count0", 64'(count), 64'd0);

      do_reset();
      enq(2'b01, 64'hF00, 64'h0, 8'hFF, 64'h0, 64'h0, 8'h0);
      drain_one("t3_pre", 64'hF00);
      for (int k = 0; k < 4; k++) begin
         enq(2'b11, 64'h1000 + 64'(16*k), 64'(k), 8'hFF, 64'h1008 + 64'(16*k), 64'(k), 8'hFF);
         if (k == 2) begin
            chk("t3_ready6", 64'(creq_ready), 64'd1);
            chk("t3_count6", 64'(count), 64'd6);
         end
      end
      chk("t3_ready8", 64'(creq_ready), 64'd0);
      chk("t3_count8", 64'(count), 64'd8);
      tick(); tick(); tick();
      chk("t3_hold_addr", dreq_addr, 64'h1000);
      chk("t3_hold_count", 64'(count), 64'd8);
      for (int j = 0; j < 8; j++) begin
         drain_one($sformatf("t3_order%0d", j), 64'h1000 + 64'(8*j));
         if (j == 0) begin
            chk("t3_count7", 64'(count), 64'd7);
            chk("t3_ready7", 64'(creq_ready), 64'd0);
         end
      end
      chk("t3_empty", 64'(empty), 64'd1);

      do_reset();
      vecs[0] = '{64'h100, 8'h0F, 64'h0000_0000_AAAA_BBBB};
      vecs[1] = '{64'h107, 8'h0F, 64'h0000_0000_AAAA_BBBB};
      vecs[2] = '{64'h208, 8'hF0, 64'h1234_9900_0000_0000};
      vecs[3] = '{64'h20F, 8'hF0, 64'h1234_9900_0000_0000};
      vecs[4] = '{64'h300, 8'h00, 64'h0};
      vecs[5] = '{64'h8000_0000_0000_0100, 8'h00, 64'h0};
      lq_addr = 64'h100;
      creq_valid = 2'b11;
      creq_addr[0] = 64'h100; creq_data[0] = 64'h0000_0000_AAAA_AAAA; creq_strobe[0] = 8'h0F;
      creq_addr[1] = 64'h104; creq_data[1] = 64'h0000_0000_0000_BBBB; creq_strobe[1] = 8'h03;
      #1;
      chk("t4_same_cycle", 64'(lq_strobe), 64'h0);
      tick();
      creq_valid = '0;
      enq(2'b11, 64'h208, 64'h1234_5678_0000_0000, 8'hF0, 64'h20A, 64'h0000_9900_0000_0000, 8'h30);
      for (int i = 0; i < 6; i++) begin
         lq_addr = vecs[i].lq;
         #1;
         chk($sformatf("t4_strb%0d", i), 64'(lq_strobe), 64'(vecs[i].strb));
         chk($sformatf("t4_data%0d", i), lq_data, vecs[i].data);
      end
      lq_addr = 64'h100;
      drain_one("t4_popA", 64'h100);
      chk("t4_after_strb", 64'(lq_strobe), 64'h03);
      chk("t4_after_data", lq_data, 64'h0000_0000_0000_BBBB);

      do_reset();
      enq(2'b01, 64'h500, 64'h5555_5555_5555_5555, 8'hFF, 64'h0, 64'h0, 8'h0);
      wait_req("t5_req");
      dresp_addr_ok = 1;
      tick();
      dresp_addr_ok = 0;
      chk("t5_wait_dvalid", 64'(dreq_valid), 64'd0);
      chk("t5_count1", 64'(count), 64'd1);
      enq(2'b11, 64'h600, 64'h6, 8'hFF, 64'h608, 64'h7, 8'hFF);
      chk("t5_count3", 64'(count), 64'd3);
      lq_addr = 64'h500;
      #1;
      chk("t5_fwd_inflight", 64'(lq_strobe), 64'hFF);
      tick();
      dresp_data_ok = 1;
      tick();
      dresp_data_ok = 0;
      chk("t5_count2", 64'(count), 64'd2);
      chk("t5_fwd_gone", 64'(lq_strobe), 64'h00);
      chk("t5_next_req", 64'(dreq_valid), 64'd1);
      chk("t5_next_addr", dreq_addr, 64'h600);

      do_reset();
      enq(2'b11, 64'h700, 64'h0, 8'hFF, 64'h708, 64'h0, 8'hFF);
      enq(2'b11, 64'h710, 64'h0, 8'hFF, 64'h718, 64'h0, 8'hFF);
      enq(2'b01, 64'h720, 64'h0, 8'hFF, 64'h0, 64'h0, 8'h0);
      wait_req("t6_req");
      dresp_addr_ok = 1;
      tick();
      dresp_addr_ok = 0;
      chk("t6_count5", 64'(count), 64'd5);
      reset = 0;
      #1;
      chk("t6_dvalid", 64'(dreq_valid), 64'd0);
      chk("t6_count", 64'(count), 64'd0);
      chk("t6_empty", 64'(empty), 64'd1);
      chk("t6_ready", 64'(creq_ready), 64'd1);
      tick();
      reset = 1;
      tick();
      chk("t6_idle", 64'(dreq_valid), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
